rx_rst_sequencer: RTL

// Downstream consumer of the signal watchdog's receiver_rst (and a software reset request). Turns

---
 rtl/rx_rst_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rx_rst_sequencer.sv
// Receiver reset sequencer: converts watchdog/software reset requests into a fixed-width
// active-low decoder reset, followed by a programmable hold-off, with saturating statistics.
module rx_rst_sequencer #(
   parameter int RST_HOLD_LEN = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 enable,
   input  logic                 watchdog_rst,
   input  logic                 sw_rst,
   input  logic [15:0]          holdoff_len,
   input  logic                 clr_counts,
   output logic                 rx_rstn,
   output logic                 busy,
   output logic [1:0]           last_cause,
   output logic [CNT_WIDTH-1:0] wd_rst_count,
   output logic [CNT_WIDTH-1:0] wd_drop_count
);

   localparam int HW = (RST_HOLD_LEN > 1) ? $clog2(RST_HOLD_LEN) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ASSERT  = 2'd1,
      S_HOLDOFF = 2'd2
   } state_t;

   state_t               r_state;
   logic [HW-1:0]        r_hold_cnt;
   logic [15:0]          r_ho_cnt;
   logic                 r_rx_rstn;
   logic                 r_busy;
   logic [1:0]           r_last_cause;
   logic [CNT_WIDTH-1:0] r_wd_cnt;
   logic [CNT_WIDTH-1:0] r_drop_cnt;

   logic w_wd_req;
   logic w_trig;
   logic w_acc_inc;
   logic w_drop_inc;

   assign w_wd_req = enable & watchdog_rst;
   assign w_trig   = w_wd_req | sw_rst;

   // A watchdog request riding along with sw_rst out of HOLDOFF counts as accepted.
   assign w_acc_inc  = w_wd_req & ((r_state == S_IDLE) |
                                   ((r_state == S_HOLDOFF) & sw_rst));
   assign w_drop_inc = w_wd_req & ((r_state == S_ASSERT) |
                                   ((r_state == S_HOLDOFF) & ~sw_rst));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state      <= S_ASSERT;
         r_hold_cnt   <= HOLD_INIT;
         r_ho_cnt     <= '0;
         r_rx_rstn    <= 1'b0;
         r_busy       <= 1'b1;
         r_last_cause <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_trig) begin
                  r_state      <= S_ASSERT;
                  r_hold_cnt   <= HOLD_INIT;
                  r_rx_rstn    <= 1'b0;
                  r_busy       <= 1'b1;
                  r_last_cause <= {sw_rst, w_wd_req};
               end
            end
            S_ASSERT: begin
               if (sw_rst) begin
                  r_hold_cnt      <= HOLD_INIT;
                  r_last_cause[1] <= 1'b1;
               end else if (r_hold_cnt == '0) begin
                  r_rx_rstn <= 1'b1;
                  if (holdoff_len != 16'd0) begin
                     r_state  <= S_HOLDOFF;
                     r_ho_cnt <= holdoff_len - 16'd1;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_hold_cnt <= r_hold_cnt - HW'(1);
               end
            end
            S_HOLDOFF: begin
               if (sw_rst) begin
                  r_state      <= S_ASSERT;
                  r_hold_cnt   <= HOLD_INIT;
                  r_rx_rstn    <= 1'b0;
                  r_last_cause <= {1'b1, w_wd_req};
               end else if (r_ho_cnt == 16'd0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_ho_cnt <= r_ho_cnt - 16'd1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_rx_rstn <= 1'b1;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   // Clear has priority over a same-cycle increment; counters stick at all-ones.
   always_ff @(posedge clk) begin
      if (!rstn || clr_counts) begin
         r_wd_cnt   <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_acc_inc && (r_wd_cnt != '1))
            r_wd_cnt <= r_wd_cnt + CNT_WIDTH'(1);
         if (w_drop_inc && (r_drop_cnt != '1))
            r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end
   end

   assign rx_rstn       = r_rx_rstn;
   assign busy          = r_busy;
   assign last_cause    = r_last_cause;
   assign wd_rst_count  = r_wd_cnt;
   assign wd_drop_count = r_drop_cnt;

endmodule
